// File: rtl/pma_rx_symbol_aligner.sv
// pma_rx_symbol_aligner: locks the 10-bit symbol boundary to K28.5 commas and emits aligned symbols
module pma_rx_symbol_aligner (
    input  logic       CLK_5G,
    input  logic       Rst,
    input  logic       Ser_in,
    input  logic       Bit_En,
    input  logic       RxPolarity,
    output logic [9:0] Data_out,
    output logic       Data_Valid,
    output logic       K285,
    output logic       Symbol_Lock,
    output logic       Realign
);
    localparam logic [1:0] SEARCH = 2'd0, CONFIRM = 2'd1, LOCKED = 2'd2;
    logic [9:0] sh_q, sh_d, data_q, data_d, nxt;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] state_q, state_d;
    logic valid_q, valid_d, k_q, k_d, realign_q, realign_d;
    logic comma, boundary, searching, emit;
    always_comb begin
        nxt = {Ser_in ^ RxPolarity, sh_q[9:1]};
        comma = (nxt == 10'h17C) || (nxt == 10'h283);
        boundary = cnt_q == 4'd9;
        searching = state_q == SEARCH;
        emit = Bit_En && (comma || (boundary && !searching));
        realign_d = Bit_En && comma && !boundary && !searching;
        sh_d = Bit_En ? nxt : sh_q;
        cnt_d = !Bit_En ? cnt_q : emit ? 4'd0 : searching ? cnt_q : cnt_q + 4'd1;
        state_d = !Bit_En ? state_q :
                  searching ? (comma ? CONFIRM : SEARCH) :
                  realign_d ? CONFIRM :
                  (state_q == CONFIRM && boundary && comma) ? LOCKED : state_q;
        data_d = emit ? nxt : data_q;
        valid_d = emit;
        k_d = emit && comma;
    end
    always_ff @(posedge CLK_5G or posedge Rst) begin
        if (Rst) begin
            sh_q <= '0;
            cnt_q <= '0;
            state_q <= SEARCH;
            data_q <= '0;
            valid_q <= 1'b0;
            k_q <= 1'b0;
            realign_q <= 1'b0;
        end else begin
            sh_q <= sh_d;
            cnt_q <= cnt_d;
            state_q <= state_d;
            data_q <= data_d;
            valid_q <= valid_d;
            k_q <= k_d;
            realign_q <= realign_d;
        end
    end
    assign Data_out = data_q;
    assign Data_Valid = valid_q;
    assign K285 = k_q;
    assign Realign = realign_q;
    assign Symbol_Lock = state_q == LOCKED;
endmodule

// File: tb/tb_pma_rx_symbol_aligner.sv
// tb_pma_rx_symbol_aligner: randomized scoreboard bench against a position-based alignment model
module tb_pma_rx_symbol_aligner;
    logic CLK_5G = 1'b0, Rst = 1'b1, Ser_in = 1'b0, Bit_En = 1'b0, RxPolarity = 1'b0;
    logic [9:0] Data_out;
    logic Data_Valid, K285, Symbol_Lock, Realign;

    pma_rx_symbol_aligner dut (
        .CLK_5G(CLK_5G), .Rst(Rst), .Ser_in(Ser_in), .Bit_En(Bit_En), .RxPolarity(RxPolarity),
        .Data_out(Data_out), .Data_Valid(Data_Valid), .K285(K285),
        .Symbol_Lock(Symbol_Lock), .Realign(Realign)
    );

    always #5 CLK_5G = ~CLK_5G;

    typedef struct {
        logic [9:0] data;
        logic       k;
        logic       lock;
        logic       rea;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int cyc = 0;
    int n_cmp = 0, n_err = 0;
    logic pol = 1'b0;
    bit gap_mode = 0;
    logic [9:0] cur_data = '0;
    logic cur_lock = 1'b0;

    logic [9:0] mwin;
    int mn, manchor;
    logic mlocked;

    always @(posedge CLK_5G) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mwin = '0;
        mn = 0;
        manchor = -1;
        mlocked = 1'b0;
        q.delete();
    endtask

    task automatic push(input logic [9:0] d, input logic k, input logic lk, input logic rea);
        exp_t e;
        e.data = d; e.k = k; e.lock = lk; e.rea = rea; e.cyc = cyc + 1;
        q.push_back(e);
    endtask

    // Alignment is an anchor bit index: any comma not a multiple of 10 bits past it moves it.
    task automatic model_step(input logic b);
        logic c, at_b;
        mwin = {b, mwin[9:1]};
        mn++;
        c = (mwin == 10'h17C) || (mwin == 10'h283);
        at_b = (manchor >= 0) && ((mn - manchor) % 10 == 0);
        if (at_b) begin
            if (c) mlocked = 1'b1;
            push(mwin, c, mlocked, 1'b0);
        end else if (c) begin
            push(mwin, 1'b1, 1'b0, manchor >= 0);
            manchor = mn;
            mlocked = 1'b0;
        end
    endtask

    always @(negedge CLK_5G) begin
        if (Rst) begin
            cur_data = '0;
            cur_lock = 1'b0;
        end else if (Data_Valid) begin
            if (q.size() == 0) chk("unexpected_valid", Data_Valid, 1'b0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("valid_cycle", cyc, e.cyc);
                chk("data_out", Data_out, e.data);
                chk("k285", K285, e.k);
                chk("symbol_lock", Symbol_Lock, e.lock);
                chk("realign", Realign, e.rea);
                cur_data = e.data;
                cur_lock = e.lock;
            end
        end else begin
            if (q.size() != 0 && q[0].cyc <= cyc) begin
                chk("missing_valid", Data_Valid, 1'b1);
                void'(q.pop_front());
            end
            chk("idle_k285", K285, 1'b0);
            chk("idle_realign", Realign, 1'b0);
            chk("hold_data", Data_out, cur_data);
            chk("hold_lock", Symbol_Lock, cur_lock);
        end
    end

    task automatic drive_bit(input logic b);
        if (gap_mode && $urandom_range(0, 3) == 0) begin
            Bit_En = 1'b0;
            repeat ($urandom_range(1, 5)) begin
                Ser_in = 1'($urandom_range(0, 1));
                @(posedge CLK_5G); #1;
            end
        end
        Ser_in = b ^ pol;
        RxPolarity = pol;
        Bit_En = 1'b1;
        model_step(b);
        @(posedge CLK_5G); #1;
    endtask

    task automatic send_sym(input logic [9:0] v);
        for (int i = 0; i < 10; i++) drive_bit(v[i]);
    endtask

    task automatic drain();
        Bit_En = 1'b0;
        for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge CLK_5G);
        chk("drain_pending", q.size(), 0);
        @(posedge CLK_5G); #1;
    endtask

    task automatic do_reset();
        Bit_En = 1'b0;
        #2 Rst = 1'b1;
        #1;
        chk("rst_data", Data_out, 10'h0);
        chk("rst_valid", Data_Valid, 1'b0);
        chk("rst_k285", K285, 1'b0);
        chk("rst_lock", Symbol_Lock, 1'b0);
        chk("rst_realign", Realign, 1'b0);
        model_reset();
        @(posedge CLK_5G); #1;
        Rst = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge CLK_5G);
        #1 Rst = 1'b0;
        chk("init_lock", Symbol_Lock, 1'b0);

        send_sym(10'h17C); send_sym(10'h283); send_sym(10'h155);
        drain();
        chk("lock_after_two_commas", Symbol_Lock, 1'b1);
        chk("lock_last_data", Data_out, 10'h155);

        drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
        send_sym(10'h17C);
        drain();
        chk("realign_drops_lock", Symbol_Lock, 1'b0);
        chk("realign_data", Data_out, 10'h17C);
        send_sym(10'h283);
        drain();
        chk("relock", Symbol_Lock, 1'b1);

        send_sym(10'h155);
        drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0);
        do_reset();
        repeat (3) send_sym(10'h155);
        drain();
        chk("no_lock_after_reset", Symbol_Lock, 1'b0);
        chk("no_data_after_reset", Data_out, 10'h0);

        do_reset();
        pol = 1'b1;
        send_sym(10'h17C); send_sym(10'h283); send_sym(10'h155);
        drain();
        chk("pol_lock", Symbol_Lock, 1'b1);
        chk("pol_data", Data_out, 10'h155);
        pol = 1'b0;

        do_reset();
        send_sym(10'h17C);
        drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0);
        send_sym(10'h17C);
        drain();
        chk("false_comma_no_lock", Symbol_Lock, 1'b0);
        send_sym(10'h155);
        drain();
        chk("false_comma_data_no_lock", Symbol_Lock, 1'b0);
        send_sym(10'h283);
        drain();
        chk("false_comma_confirmed", Symbol_Lock, 1'b1);

        do_reset();
        gap_mode = 1;
        send_sym(10'h17C); send_sym(10'h283);
        for (int i = 0; i < 6; i++) begin
            send_sym(10'h155);
            send_sym(i[0] ? 10'h17C : 10'h283);
        end
        drain();
        chk("gap_lock_kept", Symbol_Lock, 1'b1);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) == 0) pol = ~pol;
            if ($urandom_range(0, 39) == 0) send_sym($urandom_range(0, 1) ? 10'h17C : 10'h283);
            else drive_bit(1'($urandom_range(0, 1)));
        end
        gap_mode = 0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pma_rx_symbol_aligner.md
# pma_rx_symbol_aligner

Receive-side 10-bit symbol aligner for the PMA. It consumes the recovered serial bit stream, one bit per enabled clock, and applies optional polarity inversion. It finds K28.5 commas in either running disparity, locks the 10-bit symbol boundary to them and delivers aligned 10-bit symbols with a valid strobe. It sits after the CDR, in the recovered-clock domain, and is the receiving counterpart of the PMA_TX serializer. Bit order: the first bit on the wire (8b/10b bit a) lands in Data_out[0].

## Interface
- No parameters; symbol width fixed at 10.
- CLK_5G  input  1  recovered bit-rate clock; all logic on its rising edge.
- Rst  input  1  reset; one clock, reset asynchronous active-high.
- Ser_in  input  1  recovered serial bit.
- Bit_En  input  1  Ser_in is valid this cycle; when low, all state holds.
- RxPolarity  input  1  when 1, each bit is inverted before use (b = Ser_in ^ RxPolarity).
- Data_out  output  10  aligned symbol; Data_out[0] is the earliest-received bit.
- Data_Valid  output  1  one-cycle strobe, Data_out is new.
- K285  output  1  qualifies Data_Valid; the emitted symbol is a comma.
- Symbol_Lock  output  1  high while in LOCKED.
- Realign  output  1  one-cycle pulse when the boundary moves while in CONFIRM/LOCKED.

## Operation
- Window register sh[9:0]. On each Bit_En cycle: nxt = {b, sh[9:1]}, then sh <= nxt. sh[0] is the oldest bit.
- comma = (nxt == 10'h17C) or (nxt == 10'h283). These are K28.5 RD- 0011111010 and RD+ 1100000101, written a..j, mapped with a in bit 0.
- Phase counter cnt[3:0], range 0..9. boundary = (cnt == 9).
- States: SEARCH (reset), CONFIRM, LOCKED. All transitions below happen only on Bit_En cycles.
- **SEARCH**
  - comma: emit nxt with K285=1, cnt<=0, go to CONFIRM.
  - otherwise: no emit, cnt unchanged.
- **CONFIRM**
  - boundary: emit nxt, cnt<=0. If comma, K285=1 and go to LOCKED; otherwise stay.
  - not boundary, comma: realign. Emit nxt with K285=1, cnt<=0, Realign=1, stay in CONFIRM.
  - not boundary, no comma: cnt<=cnt+1.
- **LOCKED**
  - boundary: emit nxt, cnt<=0. K285 = comma. Stay in LOCKED; non-comma data never drops lock.
  - not boundary, comma: realign. Emit, K285=1, cnt<=0, Realign=1, go to CONFIRM. Symbol_Lock drops.
  - not boundary, no comma: cnt<=cnt+1.
- "Emit" means: Data_out<=nxt, Data_Valid<=1, K285 as stated.
- On every cycle without an emit: Data_Valid<=0, K285<=0, and Data_out holds its value.
- Realign is 0 on every cycle except a realign event.
- A comma arriving exactly at the boundary is not a realign.
- Bit_En low: sh, cnt and state hold. Data_Valid, K285 and Realign go to 0.
- RxPolarity may change at any time. It affects only bits sampled after the change; there is no flush.

## Timing
- All outputs are registered.
- A symbol appears on Data_out/Data_Valid one clock after its last bit (bit j) is sampled.
- With continuous Bit_En, Data_Valid pulses in CONFIRM/LOCKED are exactly 10 clocks apart, except after a realign.
- Lock needs two commas exactly 10·k bits apart with no misaligned comma between them. Symbol_Lock rises on the same clock edge as the second comma's Data_Valid.
- Reset values: sh=0, cnt=0, state=SEARCH, Data_out=0, Data_Valid=0, K285=0, Symbol_Lock=0, Realign=0.
- Reset asserted mid-symbol clears everything immediately, with no clock needed. After release, alignment restarts from SEARCH.

## Test plan
- **Reset:** assert Rst mid-stream, check all outputs are 0 asynchronously. Release and feed 30 non-comma bits (0x155 repeating) -> Data_Valid stays 0, Symbol_Lock=0.
- **Lock:** continuous Bit_En; send RD- comma, RD+ comma, then D-symbol 0x2AA (bits a..j) -> Data_out=0x17C with K285=1, then 0x283 with K285=1 and Symbol_Lock=1, then 0x155 with K285=0. Valid pulses are 10 clocks apart.
- **Polarity:** RxPolarity=1; send the bitwise complement of the lock stream -> identical Data_out sequence and lock.
- **Realign:** while LOCKED, insert 3 filler bits, then a comma -> Realign pulses once with Data_out=0x17C and K285=1. Symbol_Lock drops, and re-asserts on the next comma 10 bits later.
- **Bit_En gaps:** drive Bit_En low for random 1–5 cycle gaps inside symbols -> the symbol stream is unchanged. Data_Valid never asserts while Bit_En is low, and lock is kept.
- **False comma:** a data stream containing a comma pattern that straddles the boundary while in CONFIRM -> realign to the new position, and no LOCKED until a confirming comma arrives.
